// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared data-memory port: one access at a time, issue -> read wait -> response.
// Define MEM_ARB_ADDR_CHECK_EN to reject accesses at or above MEM_BYTES (granted, no memory strobe, err pulse).
//
// state | meaning
// IDLE  | sample requests, pick a winner, latch its command
// ISSUE | drive memory port for one cycle, pulse winner's gnt
// WAIT  | read latency count-down, capture mem_dout on terminal count
// RESP  | pulse winner's rvalid
module mem_arbiter #(
  parameter int RD_LAT    = 1,
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        prog,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_wea,
  output logic [3:0]  mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

  state_e      state_q;
  logic        last_q, win_q, we_q, rej_q;
  logic [1:0]  cnt_q;
  logic [1:0]  gnt_q, rvalid_q;
  logic        wea_q, err_q;
  logic [3:0]  en_q;
  logic [31:0] addr_q, din_q, rdata0_q, rdata1_q;

  logic        win_d, sel_we, rej_d;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr, sel_wdata;

  // prog gives requester 1 strict priority; otherwise ties go to the port not granted last
  always_comb begin
    if (prog && m1_req)        win_d = 1'b1;
    else if (m0_req && m1_req) win_d = ~last_q;
    else                       win_d = m1_req;
    sel_we    = win_d ? m1_we    : m0_we;
    sel_be    = win_d ? m1_be    : m0_be;
    sel_addr  = win_d ? m1_addr  : m0_addr;
    sel_wdata = win_d ? m1_wdata : m0_wdata;
    rej_d     = CHECK_EN && (sel_addr >= ADDR_LIMIT);
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      rej_q    <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      wea_q    <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      wea_q    <= 1'b0;
      en_q     <= '0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            win_q  <= win_d;
            we_q   <= sel_we;
            rej_q  <= rej_d;
            last_q <= win_d;
            addr_q <= sel_addr;
            if (sel_we) din_q <= sel_wdata;
            gnt_q  <= win_d ? 2'b10 : 2'b01;
            wea_q  <= sel_we && !rej_d;
            en_q   <= rej_d ? 4'h0 : (sel_we ? sel_be : 4'hF);
            err_q  <= rej_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= 2'(RD_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            if (win_q) rdata1_q <= rej_q ? 32'hDEADBEEF : mem_dout;
            else       rdata0_q <= rej_q ? 32'hDEADBEEF : mem_dout;
            rvalid_q <= win_q ? 2'b10 : 2'b01;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_wea   = wea_q;
  assign mem_en    = en_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
// Also covers the rejected-access path when MEM_ARB_ADDR_CHECK_EN is defined.
module tb_mem_arbiter;
  localparam int RD_LAT    = 1;
  localparam int MEM_BYTES = 4096;
`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        prog = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [3:0]  be [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wea, err;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_en;

  mem_arbiter #(.RD_LAT(RD_LAT), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .Rst(Rst), .prog(prog),
    .m0_req(req[0]), .m0_we(we[0]), .m0_be(be[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_be(be[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wea(mem_wea), .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .err(err)
  );

  always #5 clk = ~clk;

  // memory stand-in: byte-enabled writes, reads delivered RD_LAT cycles after the issue cycle
  logic [31:0] mem_arr [1024];
  logic [31:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_wea)
      for (int b = 0; b < 4; b++)
        if (mem_en[b]) mem_arr[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
    pipe[0] <= mem_arr[mem_addr[11:2]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout = pipe[RD_LAT-1];

  logic [31:0] ref_mem [1024];
  logic [31:0] exp_rd [2];
  int          last_ptr;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input bit w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; be[p] = b; addr[p] = a; wdata[p] = d;
  endtask

  task automatic rand_cmd(input int p, input bit wr_only);
    drive(p, wr_only ? 1'b1 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          32'($urandom_range(0, MEM_BYTES - 1)), $urandom);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, {m1_gnt, m0_gnt}, 0);
    chk({tag, "_rvalid"}, {m1_rvalid, m0_rvalid}, 0);
    chk({tag, "_wea"}, mem_wea, 0);
    chk({tag, "_en"}, mem_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_din"}, mem_din, 0);
    chk({tag, "_rdata0"}, m0_rdata, 0);
    chk({tag, "_rdata1"}, m1_rdata, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Entered during an IDLE cycle (before its closing edge); returns at the negedge of the next IDLE cycle.
  task automatic serve(input int n, input bit refill, input bit wr_only);
    for (int k = 0; k < n; k++) begin
      int          w;
      bit          ow, oob;
      logic [3:0]  ob;
      logic [31:0] a, wd;
      if (req == 2'b00) break;
      if (prog && req[1])  w = 1;
      else if (req == 2'b11) w = 1 - last_ptr;
      else                 w = req[1] ? 1 : 0;
      ow = we[w]; ob = be[w]; a = addr[w]; wd = wdata[w];
      oob = CHK && (a >= MEM_BYTES);
      @(posedge clk); @(negedge clk);
      chk("gnt0", m0_gnt, w == 0);
      chk("gnt1", m1_gnt, w == 1);
      chk("issue_wea", mem_wea, ow && !oob);
      chk("issue_en", mem_en, oob ? 4'h0 : (ow ? ob : 4'hF));
      chk("issue_addr", mem_addr, a);
      if (ow) chk("issue_din", mem_din, wd);
      chk("issue_err", err, oob);
      last_ptr = w;
      if (refill) rand_cmd(w, wr_only);
      else req[w] = 1'b0;
      if (ow) begin
        if (!oob)
          for (int b = 0; b < 4; b++)
            if (ob[b]) ref_mem[a[11:2]][8*b +: 8] = wd[8*b +: 8];
      end else begin
        for (int i = 0; i < RD_LAT; i++) begin
          @(negedge clk);
          chk("wait_en", mem_en, 0);
          chk("wait_rvalid", {m1_rvalid, m0_rvalid}, 0);
          chk("wait_addr", mem_addr, a);
        end
        @(negedge clk);
        exp_rd[w] = oob ? 32'hDEADBEEF : ref_mem[a[11:2]];
        chk("rvalid0", m0_rvalid, w == 0);
        chk("rvalid1", m1_rvalid, w == 1);
      end
      chk("rdata0", m0_rdata, exp_rd[0]);
      chk("rdata1", m1_rdata, exp_rd[1]);
      @(negedge clk);
      chk("idle_gnt", {m1_gnt, m0_gnt}, 0);
      chk("idle_en", mem_en, 0);
      chk("idle_rvalid", {m1_rvalid, m0_rvalid}, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      be[p] = '0; addr[p] = '0; wdata[p] = '0; exp_rd[p] = '0;
    end
    last_ptr = 1;

    #2 Rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    drive(0, 1'b1, 4'b0011, 32'h10, 32'hA5A51234);
    serve(1, 1'b0, 1'b0);
    drive(1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
    serve(1, 1'b0, 1'b0);
    drive(0, 1'b0, 4'hF, 32'h20, 32'h0);
    serve(1, 1'b0, 1'b0);
    chk("read_value", m0_rdata, 32'hCAFEF00D);
    drive(0, 1'b0, 4'hF, 32'h10, 32'h0);
    serve(1, 1'b0, 1'b0);
    chk("partial_write_read", m0_rdata, 32'h00001234);

    // reset while a read is in WAIT: outputs clear at once and the read never responds
    drive(0, 1'b0, 4'hF, 32'h20, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("midread_gnt", m0_gnt, 1);
    req[0] = 1'b0;
    @(negedge clk);
    Rst = 1'b0;
    #1 check_all_zero("midread_reset");
    exp_rd[0] = '0; exp_rd[1] = '0; last_ptr = 1;
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_rvalid", {m1_rvalid, m0_rvalid}, 0);
    end

    prog = 1'b0;
    rand_cmd(0, 1'b1);
    rand_cmd(1, 1'b1);
    serve(6, 1'b1, 1'b1);
    prog = 1'b1;
    serve(4, 1'b1, 1'b1);
    chk("prio_last", last_ptr, 1);
    prog = 1'b0;
    serve(1, 1'b1, 1'b1);
    chk("prio_release_m0", last_ptr, 0);
    req = 2'b00;
    @(negedge clk);

`ifdef MEM_ARB_ADDR_CHECK_EN
    drive(1, 1'b0, 4'hF, 32'h2000, 32'h0);
    serve(1, 1'b0, 1'b0);
    chk("oob_rdata", m1_rdata, 32'hDEADBEEF);
    drive(0, 1'b1, 4'hF, 32'h1000, 32'h12345678);
    serve(1, 1'b0, 1'b0);
`endif

    repeat (80) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_gnt", {m1_gnt, m0_gnt}, 0);
        chk("gap_en", mem_en, 0);
      end
      prog = 1'($urandom_range(0, 1));
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 3) != 0) rand_cmd(p, 1'b0);
      serve(2, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
